// File: rtl/sonic_key_sequencer_if.sv
// Key-load and round-key handshake bundle for sonic_key_sequencer.
// The rewind strobe exists only when SONIC_KS_REWIND_EN is defined.
interface sonic_key_sequencer_if #(
  parameter int IW = 8
);
  logic [127:0]  key_in;
  logic          key_valid;
  logic          key_ready;
  logic          abort;
  logic [127:0]  rk_data;
  logic [IW-1:0] rk_idx;
  logic          rk_last;
  logic          rk_valid;
  logic          rk_ready;
  logic          busy;
  logic          done;
`ifdef SONIC_KS_REWIND_EN
  logic          rewind;
`endif

  // Both channels use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; the offering side holds its payload stable
  // until then, and valid never waits on ready.
  modport master (
`ifdef SONIC_KS_REWIND_EN
    output rewind,
`endif
    output key_in, key_valid, abort, rk_ready,
    input  key_ready, rk_data, rk_idx, rk_last, rk_valid, busy, done
  );

  modport slave (
`ifdef SONIC_KS_REWIND_EN
    input  rewind,
`endif
    input  key_in, key_valid, abort, rk_ready,
    output key_ready, rk_data, rk_idx, rk_last, rk_valid, busy, done
  );
endinterface

// File: rtl/sonic_key_sequencer.sv
// Iterative Sonic 64x128 round-key sequencer: one key-schedule step per accepted round key.
// Optional replay of the last master key via the rewind strobe when SONIC_KS_REWIND_EN is defined.
module sonic_key_sequencer #(
  parameter int NR = 24,
  parameter int IW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  sonic_key_sequencer_if.slave  sk,
  output logic                  o_dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NR - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [127:0]  r_key;
  logic [IW-1:0] r_idx;
  logic          r_done;
  logic          w_load;
  logic          w_step;
  logic          w_finish;
`ifdef SONIC_KS_REWIND_EN
  logic [127:0]  r_master;
  logic          r_loaded;
  logic          w_rewind;
`endif

  function automatic logic [63:0] rotl64(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] s);
    logic [63:0] lo;
    logic [63:0] hi;
    logic [63:0] y;
    logic [63:0] t;
    logic [63:0] x;
    lo = s[63:0];
    hi = s[127:64];
    y  = rotl64(lo, 1) ^ rotl64(lo, 8) ^ rotl64(lo, 10);
    t  = hi ^ rotl64(lo, 1) ^ (rotl64(lo, 12) & lo);
    // Bit permutation: the 6-bit cast performs the mod-64 wrap.
    for (int i = 0; i < 64; i++) begin
      x[i] = t[6'(15 * i)];
    end
    return {y, x};
  endfunction

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
`ifdef SONIC_KS_REWIND_EN
    w_rewind     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef SONIC_KS_REWIND_EN
        if (sk.rewind && r_loaded) begin
          w_rewind     = 1'b1;
          w_next_state = S_RUN;
        end else
`endif
        if (sk.key_valid) begin
          w_load       = 1'b1;
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        // abort wins over rewind, which wins over the output handshake
        if (sk.abort) begin
          w_next_state = S_IDLE;
        end
`ifdef SONIC_KS_REWIND_EN
        else if (sk.rewind) begin
          w_rewind = 1'b1;
        end
`endif
        else if (sk.rk_ready) begin
          if (r_idx == LAST_IDX) begin
            w_finish     = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_finish;
      if (w_load) begin
        r_key <= sk.key_in;
        r_idx <= '0;
      end
`ifdef SONIC_KS_REWIND_EN
      else if (w_rewind) begin
        r_key <= r_master;
        r_idx <= '0;
      end
`endif
      else if (w_step) begin
        r_key <= key_step(r_key);
        r_idx <= r_idx + IW'(1);
      end
    end
  end

`ifdef SONIC_KS_REWIND_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_master <= '0;
      r_loaded <= 1'b0;
    end else if (w_load) begin
      r_master <= sk.key_in;
      r_loaded <= 1'b1;
    end
  end
`endif

  assign sk.key_ready = (r_state == S_IDLE);
  assign sk.rk_valid  = (r_state == S_RUN);
  assign sk.busy      = (r_state == S_RUN);
  assign sk.rk_data   = r_key;
  assign sk.rk_idx    = r_idx;
  assign sk.rk_last   = (r_state == S_RUN) && (r_idx == LAST_IDX);
  assign sk.done      = r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_sonic_key_sequencer.sv
// Scoreboard bench for sonic_key_sequencer: expected round keys are queued at key load
// and popped on every output handshake. Define SONIC_KS_REWIND_EN to cover rewind.
module tb_sonic_key_sequencer;
  localparam int NR = 24;
  localparam int IW = 8;
  localparam int W  = 1 + IW + 128;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sonic_key_sequencer_if #(.IW(IW)) sk ();
  logic dbg_state;

  sonic_key_sequencer #(.NR(NR), .IW(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .sk          (sk.slave),
    .o_dbg_state (dbg_state)
  );

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  bit           exp_done = 1'b0;
  int           hs_count = 0;
  logic [127:0] cur_master = '0;
  int           ready_mode = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_f(input logic [127:0] s);
    logic [63:0] lo, hi, r1, r8, r10, r12, y, t, x;
    lo  = s[63:0];
    hi  = s[127:64];
    r1  = {lo[62:0], lo[63]};
    r8  = {lo[55:0], lo[63:56]};
    r10 = {lo[53:0], lo[63:54]};
    r12 = {lo[51:0], lo[63:52]};
    y   = r1 ^ r8 ^ r10;
    t   = hi ^ r1 ^ (r12 & lo);
    for (int i = 0; i < 64; i++) x[i] = t[(15 * i) % 64];
    return {y, x};
  endfunction

  task automatic push_seq(input logic [127:0] k, input bit use_ovr, input logic [127:0] ovr);
    logic [127:0] s;
    s = k;
    for (int i = 0; i < NR; i++) begin
      exp_q.push_back({(i == NR - 1) ? 1'b1 : 1'b0, IW'(i), s});
      if (i == 0 && use_ovr) s = ovr;
      else s = model_f(s);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_done) begin
        check_val("done_pulse", sk.done, 1);
        check_val("key_ready_at_done", sk.key_ready, 1);
        exp_done = 1'b0;
      end else if (sk.done) begin
        check_val("done_spurious", sk.done, 0);
      end
      if (sk.rk_valid) begin
        if (sk.abort) begin
          exp_q.delete();
        end
`ifdef SONIC_KS_REWIND_EN
        else if (sk.rewind) begin
          exp_q.delete();
          push_seq(cur_master, 1'b0, '0);
          hs_count = 0;
        end
`endif
        else if (sk.rk_ready) begin
          if (exp_q.size() == 0) begin
            check_val("unexpected_hs", 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check_val("rk_data", sk.rk_data, mon_e[127:0]);
            check_val("rk_idx", sk.rk_idx, mon_e[W-2:128]);
            check_val("rk_last", sk.rk_last, mon_e[W-1]);
            hs_count++;
            if (mon_e[W-1]) exp_done = 1'b1;
          end
        end
      end
    end
  end

  // consumer ready driver: 0 = always ready, 1 = random, other = stalled
  initial begin
    sk.rk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       sk.rk_ready = 1'b1;
        1:       sk.rk_ready = 1'($urandom_range(0, 1));
        default: sk.rk_ready = 1'b0;
      endcase
    end
  end

  task automatic load_key(input logic [127:0] k, input bit use_ovr, input logic [127:0] ovr);
    int n;
    n = 0;
    @(negedge clk);
    while (!sk.key_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!sk.key_ready) check_val("load_timeout", 0, 1);
    exp_q.delete();
    push_seq(k, use_ovr, ovr);
    hs_count   = 0;
    cur_master = k;
    @(posedge clk); #1;
    sk.key_in    = k;
    sk.key_valid = 1'b1;
    @(posedge clk); #1;
    sk.key_valid = 1'b0;
    @(negedge clk);
    check_val("load_rk_valid", sk.rk_valid, 1);
    check_val("load_busy", sk.busy, 1);
    check_val("load_key_ready", sk.key_ready, 0);
    check_val("load_idx0", sk.rk_idx, 0);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check_val("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idx(input int v);
    int n;
    n = 0;
    @(negedge clk);
    while ((sk.rk_idx !== IW'(v) || !sk.rk_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sk.rk_idx !== IW'(v)) check_val("wait_idx_timeout", sk.rk_idx, v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_key_ready"}, sk.key_ready, 1);
    check_val({tag, "_rk_valid"}, sk.rk_valid, 0);
    check_val({tag, "_busy"}, sk.busy, 0);
    check_val({tag, "_done"}, sk.done, 0);
    check_val({tag, "_rk_last"}, sk.rk_last, 0);
    check_val({tag, "_rk_idx"}, sk.rk_idx, 0);
    check_val({tag, "_rk_data"}, sk.rk_data, 0);
    check_val({tag, "_dbg_state"}, dbg_state, 0);
  endtask

  initial begin
    rst          = 1'b1;
    sk.key_in    = 128'h1234;
    sk.key_valid = 1'b1;
    sk.abort     = 1'b0;
`ifdef SONIC_KS_REWIND_EN
    sk.rewind    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    sk.key_valid = 1'b0;
    rst          = 1'b0;

    // all-zero key, full throughput, last index NR-1 cycles after index 0
    ready_mode = 0;
    load_key('0, 1'b0, '0);
    repeat (NR - 1) @(negedge clk);
    check_val("tput_idx_last", sk.rk_idx, NR - 1);
    check_val("tput_rk_last", sk.rk_last, 1);
    wait_drain(100);
    check_val("zero_hs_count", hs_count, NR);

    // key = 1 against the known second round key
    load_key(128'h1, 1'b1, 128'h0000_0000_0000_0502_0000_8000_0000_0000);
    wait_drain(100);
    check_val("one_hs_count", hs_count, NR);

    // random key with random back-pressure
    ready_mode = 1;
    load_key({$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
    wait_drain(800);
    check_val("rand_hs_count", hs_count, NR);

    // abort at index 5 together with rk_ready, then reload
    ready_mode = 0;
    load_key({$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
    wait_idx(4);
    @(posedge clk); #1;
    sk.abort = 1'b1;
    @(posedge clk); #1;
    sk.abort = 1'b0;
    @(negedge clk);
    check_val("abort_rk_valid", sk.rk_valid, 0);
    check_val("abort_key_ready", sk.key_ready, 1);
    check_val("abort_hs_count", hs_count, 5);
    load_key({$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
    wait_drain(100);
    check_val("post_abort_hs_count", hs_count, NR);

    // asynchronous reset mid-sequence at index 10
    load_key({$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
    wait_idx(9);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    exp_done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_key_ready", sk.key_ready, 1);
    check_val("post_rst_rk_valid", sk.rk_valid, 0);

`ifdef SONIC_KS_REWIND_EN
    // rewind before any load since reset is ignored
    @(posedge clk); #1;
    sk.rewind = 1'b1;
    @(posedge clk); #1;
    sk.rewind = 1'b0;
    @(negedge clk);
    check_val("rewind_idle_ignored", sk.rk_valid, 0);

    // rewind at index 12 restarts from the master key
    load_key({$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
    wait_idx(11);
    @(posedge clk); #1;
    sk.rewind = 1'b1;
    @(posedge clk); #1;
    sk.rewind = 1'b0;
    @(negedge clk);
    check_val("rewind_idx0", sk.rk_idx, 0);
    check_val("rewind_master", sk.rk_data, cur_master);
    wait_drain(100);
    check_val("rewind_hs_count", hs_count, NR);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got timeout want finish");
    $fatal(1, "bench timeout");
  end

endmodule
